// File: rtl/ppu_cpu_port_if.sv
// VRAM request/acknowledge channel between the PPU register port (master)
// and the VRAM arbiter (slave).
interface ppu_cpu_port_if #(
  parameter int VRAM_ADDR_W = 14
);
  logic                   vram_req;
  logic                   vram_we;
  logic [VRAM_ADDR_W-1:0] vram_addr;
  logic [7:0]             vram_wdata;
  logic [7:0]             vram_rdata;
  logic                   vram_ack;

  modport master (
    output vram_req, vram_we, vram_addr, vram_wdata,
    input  vram_rdata, vram_ack
  );

  modport slave (
    input  vram_req, vram_we, vram_addr, vram_wdata,
    output vram_rdata, vram_ack
  );
endinterface

// File: rtl/ppu_cpu_port.sv
// PPU CPU register port ($2000-$2007): CTRL/MASK, loopy v/t/x scroll state, OAM address,
// buffered PPUDATA over a req/ack VRAM port. Optional macro: PPU_PALETTE_DIRECT_READ_EN.
module ppu_cpu_port #(
  parameter int          VRAM_ADDR_W  = 14,
  parameter logic [13:0] PALETTE_BASE = 14'h3F00,
  parameter int          OAM_ADDR_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            reg_sel,
  input  logic                  reg_wr,
  input  logic                  reg_rd,
  input  logic [7:0]            cpu_data_in,
  output logic [7:0]            cpu_data_out,
  output logic                  rd_valid,
  input  logic                  vblank,
  input  logic                  sprite0_hit,
  input  logic                  sprite_overflow,
  output logic                  clear_vblank,
  output logic [7:0]            ctrl_out,
  output logic [7:0]            mask_out,
  output logic [14:0]           v_addr,
  output logic [14:0]           t_addr,
  output logic [2:0]            fine_x,
  input  logic                  inc_x,
  input  logic                  inc_y,
  input  logic                  copy_x,
  input  logic                  copy_y,
  output logic [OAM_ADDR_W-1:0] oam_addr,
  output logic                  oam_wr,
  output logic [7:0]            oam_wdata,
  input  logic [7:0]            oam_rdata,
  ppu_cpu_port_if.master        vram,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t                 state, state_next;
  logic [7:0]             ctrl, mask, rbuf, openbus;
  logic [14:0]            v, t, v_scroll, v_step;
  logic                   w, oam_inc, xfer_we;
  logic [VRAM_ADDR_W-1:0] xfer_addr;
  logic [7:0]             xfer_wdata;
  logic                   rd_go, data_go, scroll_hit, ack_rd;

  // A simultaneous write suppresses the read entirely.
  assign rd_go   = reg_rd & ~reg_wr;
  assign data_go = (reg_wr | rd_go) && (reg_sel == 3'd7) && (state == IDLE);
  assign ack_rd  = (state == REQ) && vram.vram_ack && !xfer_we;
  assign v_step  = v + (ctrl[2] ? 15'd32 : 15'd1);

`ifdef PPU_PALETTE_DIRECT_READ_EN
  logic pal_pending, pal_hit;
  assign pal_hit = rd_go && data_go && (v[13:0] >= PALETTE_BASE);
`else
  logic unused_palette;
  assign unused_palette = ^PALETTE_BASE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (data_go) state_next = REQ;
      REQ:     if (vram.vram_ack) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    vram.vram_req = (state == REQ);
    busy          = (state != IDLE);
  end

  assign vram.vram_we    = xfer_we;
  assign vram.vram_addr  = xfer_addr;
  assign vram.vram_wdata = xfer_wdata;

  // Renderer strobes applied in order; copies land after increments.
  always_comb begin
    v_scroll   = v;
    scroll_hit = inc_x | inc_y | copy_x | copy_y;
    if (inc_x)
      {v_scroll[10], v_scroll[4:0]} = {v_scroll[10], v_scroll[4:0]} + 6'd1;
    if (inc_y) begin
      if (v_scroll[14:12] != 3'd7) begin
        v_scroll[14:12] = v_scroll[14:12] + 3'd1;
      end else begin
        v_scroll[14:12] = 3'd0;
        if (v_scroll[9:5] == 5'd29) begin
          v_scroll[9:5] = 5'd0;
          v_scroll[11]  = ~v_scroll[11];
        end else if (v_scroll[9:5] == 5'd31) begin
          v_scroll[9:5] = 5'd0;
        end else begin
          v_scroll[9:5] = v_scroll[9:5] + 5'd1;
        end
      end
    end
    if (copy_x) begin
      v_scroll[10]  = t[10];
      v_scroll[4:0] = t[4:0];
    end
    if (copy_y) begin
      v_scroll[14:11] = t[14:11];
      v_scroll[9:5]   = t[9:5];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0; mask <= '0; rbuf <= '0; openbus <= '0;
      v <= '0; t <= '0; fine_x <= '0; w <= 1'b0;
      oam_addr <= '0; oam_wr <= 1'b0; oam_wdata <= '0; oam_inc <= 1'b0;
      cpu_data_out <= '0; rd_valid <= 1'b0; clear_vblank <= 1'b0;
      xfer_we <= 1'b0; xfer_addr <= '0; xfer_wdata <= '0;
`ifdef PPU_PALETTE_DIRECT_READ_EN
      pal_pending <= 1'b0;
`endif
    end else begin
      rd_valid     <= 1'b0;
      clear_vblank <= 1'b0;
      oam_wr       <= 1'b0;
      oam_inc      <= 1'b0;
      if (oam_inc) oam_addr <= oam_addr + OAM_ADDR_W'(1);

      if (scroll_hit)          v <= v_scroll;
      else if (state == DONE)  v <= v_step;

      if (ack_rd) rbuf <= vram.vram_rdata;
      if (data_go) begin
        xfer_we    <= reg_wr;
        xfer_addr  <= v[VRAM_ADDR_W-1:0];
        xfer_wdata <= cpu_data_in;
      end

      if (reg_wr) begin
        openbus <= cpu_data_in;
        case (reg_sel)
          3'd0: begin
            ctrl     <= cpu_data_in;
            t[11:10] <= cpu_data_in[1:0];
          end
          3'd1: mask <= cpu_data_in;
          3'd3: oam_addr <= OAM_ADDR_W'(cpu_data_in);
          3'd4: begin
            oam_wr    <= 1'b1;
            oam_wdata <= cpu_data_in;
            oam_inc   <= 1'b1;
          end
          3'd5: begin
            if (!w) begin
              t[4:0] <= cpu_data_in[7:3];
              fine_x <= cpu_data_in[2:0];
            end else begin
              t[9:5]   <= cpu_data_in[7:3];
              t[14:12] <= cpu_data_in[2:0];
            end
            w <= ~w;
          end
          3'd6: begin
            if (!w) begin
              t[13:8] <= cpu_data_in[5:0];
              t[14]   <= 1'b0;
            end else begin
              // Second write wins over any renderer strobe this cycle.
              t[7:0] <= cpu_data_in;
              v      <= {t[14:8], cpu_data_in};
            end
            w <= ~w;
          end
          default: ;
        endcase
      end else if (reg_rd) begin
        rd_valid <= 1'b1;
        case (reg_sel)
          3'd2: begin
            cpu_data_out <= {vblank, sprite0_hit, sprite_overflow, openbus[4:0]};
            clear_vblank <= 1'b1;
            w            <= 1'b0;
          end
          3'd4: cpu_data_out <= oam_rdata;
          3'd7: begin
`ifdef PPU_PALETTE_DIRECT_READ_EN
            if (pal_hit) begin
              rd_valid    <= 1'b0;
              pal_pending <= 1'b1;
            end else
`endif
            cpu_data_out <= rbuf;
          end
          default: cpu_data_out <= openbus;
        endcase
      end

`ifdef PPU_PALETTE_DIRECT_READ_EN
      if (ack_rd && pal_pending) begin
        cpu_data_out <= vram.vram_rdata;
        rd_valid     <= 1'b1;
        pal_pending  <= 1'b0;
      end
`endif
    end
  end

  assign ctrl_out = ctrl;
  assign mask_out = mask;
  assign v_addr   = v;
  assign t_addr   = t;

endmodule

// File: tb/tb_ppu_cpu_port.sv
// Scoreboard bench for ppu_cpu_port: expected read data, VRAM requests and OAM writes
// are queued by the stimulus and checked by independent monitors.
module tb_ppu_cpu_port;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  reg_sel = '0;
  logic        reg_wr = 1'b0, reg_rd = 1'b0;
  logic [7:0]  cpu_data_in = '0;
  logic [7:0]  cpu_data_out;
  logic        rd_valid;
  logic        vblank = 1'b0, sprite0_hit = 1'b0, sprite_overflow = 1'b0;
  logic        clear_vblank;
  logic [7:0]  ctrl_out, mask_out;
  logic [14:0] v_addr, t_addr;
  logic [2:0]  fine_x;
  logic        inc_x = 1'b0, inc_y = 1'b0, copy_x = 1'b0, copy_y = 1'b0;
  logic [7:0]  oam_addr;
  logic        oam_wr;
  logic [7:0]  oam_wdata;
  logic [7:0]  oam_rdata = '0;
  logic        busy;

  logic        model_ack = 1'b0, late_ack = 1'b0, ack_hold = 1'b0;
  logic [7:0]  model_rdata = '0;
  logic [7:0]  mem [0:16383];

  int          checks = 0;
  int          errors = 0;
  int          vblank_pulses = 0;
  logic [7:0]  rd_q[$];
  logic [22:0] req_q[$];
  logic [15:0] oam_q[$];

  ppu_cpu_port_if #(.VRAM_ADDR_W(14)) vif();
  assign vif.vram_ack   = model_ack | late_ack;
  assign vif.vram_rdata = model_rdata;

  always #5 clk = ~clk;

  ppu_cpu_port #(.VRAM_ADDR_W(14), .PALETTE_BASE(14'h3F00), .OAM_ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .rd_valid(rd_valid),
    .vblank(vblank), .sprite0_hit(sprite0_hit), .sprite_overflow(sprite_overflow),
    .clear_vblank(clear_vblank), .ctrl_out(ctrl_out), .mask_out(mask_out),
    .v_addr(v_addr), .t_addr(t_addr), .fine_x(fine_x),
    .inc_x(inc_x), .inc_y(inc_y), .copy_x(copy_x), .copy_y(copy_y),
    .oam_addr(oam_addr), .oam_wr(oam_wr), .oam_wdata(oam_wdata), .oam_rdata(oam_rdata),
    .vram(vif), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("check %s: %0h ok", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [2:0] s, input logic [7:0] d);
    reg_sel = s; cpu_data_in = d; reg_wr = 1'b1;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] s, input logic [7:0] exp);
    rd_q.push_back(exp);
    reg_sel = s; reg_rd = 1'b1;
    tick();
    reg_rd = 1'b0;
  endtask

  task automatic strobe(input logic ix, input logic iy, input logic cx, input logic cy);
    inc_x = ix; inc_y = iy; copy_x = cx; copy_y = cy;
    tick();
    inc_x = 1'b0; inc_y = 1'b0; copy_x = 1'b0; copy_y = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("busy_cleared", busy, 1'b0);
  endtask

  // VRAM arbiter model: acknowledges the third cycle of a request.
  initial begin : vram_model
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      model_ack = 1'b0;
      if (vif.vram_req && !ack_hold && rst_n) begin
        cnt++;
        if (cnt == 3) begin
          model_ack   = 1'b1;
          model_rdata = mem[vif.vram_addr];
          if (vif.vram_we) mem[vif.vram_addr] = vif.vram_wdata;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : rd_mon
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (clear_vblank) vblank_pulses++;
      if (rd_valid) begin
        if (rd_q.size() == 0) chk("unexpected_rd_valid", 1'b1, 1'b0);
        else begin
          e = rd_q.pop_front();
          chk("rd_data", cpu_data_out, e);
        end
      end
    end
  end

  initial begin : req_mon
    logic        prev;
    logic [22:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (vif.vram_req && !prev) begin
        if (req_q.size() == 0) chk("unexpected_vram_req", 1'b1, 1'b0);
        else begin
          e = req_q.pop_front();
          chk("vram_we", vif.vram_we, e[22]);
          chk("vram_addr", vif.vram_addr, e[21:8]);
          if (e[22]) chk("vram_wdata", vif.vram_wdata, e[7:0]);
        end
      end
      prev = vif.vram_req;
    end
  end

  initial begin : oam_mon
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (oam_wr) begin
        if (oam_q.size() == 0) chk("unexpected_oam_wr", 1'b1, 1'b0);
        else begin
          e = oam_q.pop_front();
          chk("oam_wr_addr", oam_addr, e[15:8]);
          chk("oam_wdata", oam_wdata, e[7:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h2000] = 8'hAA;
    mem[14'h2001] = 8'hBB;
    mem[14'h2002] = 8'hCC;
    mem[14'h2022] = 8'hDD;

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_cpu_data_out", cpu_data_out, 8'h00);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_v", v_addr, 15'h0000);
    chk("rst_t", t_addr, 15'h0000);
    chk("rst_fine_x", fine_x, 3'h0);
    chk("rst_ctrl", ctrl_out, 8'h00);
    chk("rst_mask", mask_out, 8'h00);
    chk("rst_oam_addr", oam_addr, 8'h00);
    chk("rst_vram_req", vif.vram_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_clear_vblank", clear_vblank, 1'b0);
    chk("rst_oam_wr", oam_wr, 1'b0);
    rst_n = 1'b1;
    tick();

    // Status read clears the write toggle left set by the reg 5 write
    cpu_write(3'd5, 8'h00);
    vblank = 1'b1;
    cpu_read(3'd2, 8'h80);
    vblank = 1'b0;
    tick(); tick();
    chk("clear_vblank_pulses", vblank_pulses, 1);

    cpu_write(3'd6, 8'h21);
    cpu_write(3'd6, 8'h08);
    chk("t_after_reg6", t_addr, 15'h2108);
    chk("v_after_reg6", v_addr, 15'h2108);

    req_q.push_back({1'b1, 14'h2108, 8'h55});
    cpu_write(3'd7, 8'h55);
    wait_idle();
    chk("v_after_data_write", v_addr, 15'h2109);

    cpu_write(3'd6, 8'h20);
    cpu_write(3'd6, 8'h00);
    chk("v_2000", v_addr, 15'h2000);
    req_q.push_back({1'b0, 14'h2000, 8'h00});
    cpu_read(3'd7, 8'h00);
    wait_idle();
    chk("v_2001", v_addr, 15'h2001);
    req_q.push_back({1'b0, 14'h2001, 8'h00});
    cpu_read(3'd7, 8'hAA);
    wait_idle();

    cpu_write(3'd0, 8'h04);
    chk("ctrl_04", ctrl_out, 8'h04);
    req_q.push_back({1'b0, 14'h2002, 8'h00});
    cpu_read(3'd7, 8'hBB);
    wait_idle();
    chk("v_2022", v_addr, 15'h2022);
    req_q.push_back({1'b0, 14'h2022, 8'h00});
    cpu_read(3'd7, 8'hCC);
    cpu_read(3'd7, 8'hCC);          // while busy: buffer only, no new request
    wait_idle();
    chk("v_2042_single_inc", v_addr, 15'h2042);
    req_q.push_back({1'b0, 14'h2042, 8'h00});
    cpu_read(3'd7, 8'hDD);
    wait_idle();
    chk("v_2062", v_addr, 15'h2062);
    cpu_write(3'd0, 8'h00);

    cpu_write(3'd5, 8'h7D);
    chk("t_coarse_x", t_addr[4:0], 5'h0F);
    chk("fine_x_5", fine_x, 3'h5);
    cpu_write(3'd5, 8'h5E);
    chk("t_coarse_y", t_addr[9:5], 5'h0B);
    chk("t_fine_y", t_addr[14:12], 3'h6);
    chk("t_616f", t_addr, 15'h616F);

    cpu_write(3'd5, 8'h00);
    cpu_write(3'd5, 8'hEF);
    strobe(1'b0, 1'b0, 1'b1, 1'b1);
    chk("v_copy_xy", v_addr, 15'h73A0);
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    chk("inc_y_row29_wrap", v_addr, 15'h0800);

    cpu_write(3'd5, 8'h00);
    cpu_write(3'd5, 8'hFF);
    strobe(1'b0, 1'b0, 1'b0, 1'b1);
    chk("v_copy_y", v_addr, 15'h73E0);
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    chk("inc_y_row31_wrap", v_addr, 15'h0000);

    cpu_write(3'd5, 8'hF8);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    chk("v_copy_x", v_addr, 15'h001F);
    cpu_read(3'd2, 8'h18);
    tick(); tick();
    chk("clear_vblank_pulses2", vblank_pulses, 2);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    chk("inc_x_wrap", v_addr, 15'h0400);

    // Reg 6 second write and inc_x on the same edge
    cpu_write(3'd6, 8'h01);
    reg_sel = 3'd6; cpu_data_in = 8'h23; reg_wr = 1'b1; inc_x = 1'b1;
    tick();
    reg_wr = 1'b0; inc_x = 1'b0;
    chk("reg6_beats_inc_x", v_addr, 15'h0123);
    chk("t_0123", t_addr, 15'h0123);

    cpu_write(3'd3, 8'hFF);
    chk("oam_addr_ff", oam_addr, 8'hFF);
    oam_q.push_back({8'hFF, 8'h12});
    cpu_write(3'd4, 8'h12);
    chk("oam_addr_during_wr", oam_addr, 8'hFF);
    tick();
    chk("oam_addr_wrap", oam_addr, 8'h00);
    oam_rdata = 8'h5A;
    cpu_read(3'd4, 8'h5A);
    tick();
    chk("oam_addr_no_inc_on_read", oam_addr, 8'h00);
    cpu_read(3'd0, 8'h12);

    // Read and write together: write lands, read is dropped
    reg_sel = 3'd1; cpu_data_in = 8'h33; reg_wr = 1'b1; reg_rd = 1'b1;
    tick();
    reg_wr = 1'b0; reg_rd = 1'b0;
    tick();
    chk("mask_33", mask_out, 8'h33);

    ack_hold = 1'b1;
    req_q.push_back({1'b1, 14'h0123, 8'h99});
    cpu_write(3'd7, 8'h99);
    tick();
    chk("req_held", vif.vram_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("req_async_drop", vif.vram_req, 1'b0);
    chk("busy_async_drop", busy, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    ack_hold = 1'b0;
    late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    tick(); tick();
    chk("late_ack_busy", busy, 1'b0);
    chk("late_ack_req", vif.vram_req, 1'b0);
    chk("late_ack_v", v_addr, 15'h0000);

    repeat (3) tick();
    chk("rd_q_empty", rd_q.size(), 0);
    chk("req_q_empty", req_q.size(), 0);
    chk("oam_q_empty", oam_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
